mem_port_arbiter: RTL and testbench

- Shares one single-ported, variable-latency memory between the CPU's instruction-fetch requester (IF) and data-access requester (D, load/store stage).
- Sits between the core datapath and the unified memory inside Top.
- Sequences each access with a fixed FSM and arbitrates D-over-IF with an anti-starvation guard.
- Returns per-requester ready/rdata pulses, which the core uses as stall-release signals.

---
 rtl/mem_port_arbiter.sv | 145 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported, variable-latency memory between
// the instruction-fetch (IF) and data-access (D) requesters. D wins ties unless
// IF has been passed over STARVE_LIMIT times in a row. Each access runs
// IDLE -> ACC -> DONE. A stalled access is aborted after TIMEOUT cycles in ACC.
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255,
    parameter int AW           = 32
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_ready,
    output logic [31:0]   if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [31:0]   d_wdata,
    input  logic [3:0]    d_be,
    output logic          d_ready,
    output logic [31:0]   d_rdata,
    output logic          bus_err,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic [3:0]    mem_be,
    input  logic [31:0]   mem_rdata,
    input  logic          mem_ack,
    output logic          owner
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [SW-1:0] STARVE_MAX  = SW'(STARVE_LIMIT);
    localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACC  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state;
    logic [SW-1:0] starve_cnt;
    logic [TW-1:0] tcnt;
    logic          err;
    logic          lat_we;
    logic [AW-1:0] lat_addr;
    logic [31:0]   lat_wdata;
    logic [3:0]    lat_be;
    logic          grant_d;

    // D wins unless IF is waiting and has already been passed over STARVE_LIMIT times
    always_comb begin
        grant_d = d_req && !(if_req && (starve_cnt == STARVE_MAX));
    end

    // Access sequencer: arbitration and field latching in IDLE, memory handshake
    // and timeout in ACC, one-cycle completion in DONE
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= S_IDLE;
            starve_cnt <= '0;
            tcnt       <= '0;
            err        <= 1'b0;
            owner      <= 1'b0;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_be     <= '0;
            if_rdata   <= '0;
            d_rdata    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (d_req || if_req) begin
                        if (grant_d) begin
                            lat_we    <= d_we;
                            lat_addr  <= d_addr;
                            lat_wdata <= d_wdata;
                            lat_be    <= d_be;
                            owner     <= 1'b1;
                        end else begin
                            lat_we    <= 1'b0;
                            lat_addr  <= if_addr;
                            lat_wdata <= '0;
                            lat_be    <= 4'hF;
                            owner     <= 1'b0;
                        end
                        if (grant_d && if_req) begin
                            if (starve_cnt != STARVE_MAX)
                                starve_cnt <= starve_cnt + 1'b1;
                        end else begin
                            starve_cnt <= '0;
                        end
                        // tcnt holds the number of the current ACC cycle, starting at 1
                        tcnt  <= TW'(1);
                        state <= S_ACC;
                    end
                end
                S_ACC: begin
                    if (mem_ack) begin
                        if (owner)
                            d_rdata <= lat_we ? 32'h0 : mem_rdata;
                        else
                            if_rdata <= mem_rdata;
                        state <= S_DONE;
                    end else if (tcnt == TIMEOUT_MAX) begin
                        err <= 1'b1;
                        if (owner)
                            d_rdata <= '0;
                        else
                            if_rdata <= '0;
                        state <= S_DONE;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                S_DONE: begin
                    err   <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Memory side is driven from latched fields only while an access is in flight
    always_comb begin
        mem_req   = (state == S_ACC);
        mem_we    = mem_req && lat_we;
        mem_addr  = mem_req ? lat_addr : '0;
        mem_wdata = mem_req ? lat_wdata : '0;
        mem_be    = mem_req ? lat_be : 4'h0;
    end

    // Completion pulses go to the current owner for the single DONE cycle
    always_comb begin
        if_ready = (state == S_DONE) && !owner;
        d_ready  = (state == S_DONE) && owner;
        bus_err  = (state == S_DONE) && err;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter: fetch, store/fetch contention,
// starvation guard, timeout, reset mid-access and ack/timeout tie.
module tb_mem_port_arbiter;

    localparam int STARVE_LIMIT = 4;
    localparam int TIMEOUT      = 255;
    localparam int AW           = 32;

    logic          CLK = 1'b0;
    logic          RESET;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_ready;
    logic [31:0]   if_rdata;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [31:0]   d_wdata;
    logic [3:0]    d_be;
    logic          d_ready;
    logic [31:0]   d_rdata;
    logic          bus_err;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_be;
    logic [31:0]   mem_rdata;
    logic          mem_ack;
    logic          owner;

    int tests  = 0;
    int failed = 0;

    mem_port_arbiter #(
        .STARVE_LIMIT(STARVE_LIMIT),
        .TIMEOUT(TIMEOUT),
        .AW(AW)
    ) dut (
        .CLK(CLK), .RESET(RESET),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_ready(d_ready), .d_rdata(d_rdata), .bus_err(bus_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .owner(owner)
    );

    always #5 CLK = ~CLK;

    // Advance to just after the next rising edge; inputs are driven here
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Compare at the falling edge of the current cycle
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        step();
        step();
        RESET = 1'b0;
    endtask

    initial begin
        RESET = 1'b1; if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_addr = '0;
        d_wdata = '0; d_be = '0; mem_rdata = '0; mem_ack = 0;
        step();
        step();
        @(negedge CLK);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_if_ready", if_ready, 0);
        chk("rst_d_ready", d_ready, 0);
        chk("rst_owner", owner, 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_d_rdata", d_rdata, 0);
        chk("rst_bus_err", bus_err, 0);
        chk("rst_mem_be", mem_be, 0);
        step();
        RESET = 1'b0;

        // Single fetch
        if_req = 1; if_addr = 32'h0000_0040;
        @(negedge CLK);
        chk("f_c0_mem_req", mem_req, 0);
        step();
        mem_ack = 1; mem_rdata = 32'h2008_0005;
        @(negedge CLK);
        chk("f_c1_mem_req", mem_req, 1);
        chk("f_c1_mem_be", mem_be, 4'hF);
        chk("f_c1_mem_we", mem_we, 0);
        chk("f_c1_mem_addr", mem_addr, 32'h40);
        step();
        mem_ack = 0; if_req = 0; mem_rdata = '0;
        @(negedge CLK);
        chk("f_c2_if_ready", if_ready, 1);
        chk("f_c2_if_rdata", if_rdata, 32'h2008_0005);
        chk("f_c2_d_ready", d_ready, 0);
        chk("f_c2_bus_err", bus_err, 0);
        chk("f_c2_mem_req", mem_req, 0);
        step();
        @(negedge CLK);
        chk("f_c3_if_ready", if_ready, 0);
        chk("f_c3_mem_req", mem_req, 0);
        chk("f_c3_rdata_hold", if_rdata, 32'h2008_0005);

        // Store vs fetch contention: D first, then IF
        step();
        if_req = 1; if_addr = 32'h80;
        d_req = 1; d_we = 1; d_addr = 32'h100; d_wdata = 32'hCAFEBABE; d_be = 4'b0011;
        step();
        @(negedge CLK);
        chk("c_owner_d", owner, 1);
        chk("c_mem_we", mem_we, 1);
        chk("c_mem_be", mem_be, 4'h3);
        chk("c_mem_wdata", mem_wdata, 32'hCAFEBABE);
        chk("c_mem_addr", mem_addr, 32'h100);
        step();
        d_addr = 32'h999;
        mem_ack = 1; mem_rdata = 32'h1234_5678;
        @(negedge CLK);
        chk("c_addr_latched", mem_addr, 32'h100);
        chk("c_no_ready_yet", d_ready, 0);
        step();
        mem_ack = 0; d_req = 0; d_we = 0;
        @(negedge CLK);
        chk("c_d_ready", d_ready, 1);
        chk("c_if_ready_0", if_ready, 0);
        chk("c_store_rdata", d_rdata, 0);
        step();
        @(negedge CLK);
        chk("c_idle_mem_req", mem_req, 0);
        step();
        @(negedge CLK);
        chk("c_if_owner", owner, 0);
        chk("c_if_addr", mem_addr, 32'h80);
        chk("c_if_we", mem_we, 0);
        chk("c_if_be", mem_be, 4'hF);
        chk("c_if_wdata", mem_wdata, 0);
        mem_ack = 1; mem_rdata = 32'hA5A5_0001;
        step();
        mem_ack = 0; if_req = 0;
        @(negedge CLK);
        chk("c_if_ready", if_ready, 1);
        chk("c_if_rdata", if_rdata, 32'hA5A5_0001);
        chk("c_d_rdata_hold", d_rdata, 0);
        step();

        // Starvation guard: 4 D grants, IF, then D again (counter cleared)
        do_reset();
        if_req = 1; if_addr = 32'h44; d_req = 1; d_we = 0; d_addr = 32'h300;
        for (int n = 0; n < 6; n++) begin
            logic exp_owner;
            exp_owner = (n == 4) ? 1'b0 : 1'b1;
            step();
            @(negedge CLK);
            chk("s_owner", owner, exp_owner);
            chk("s_mem_addr", mem_addr, exp_owner ? 32'h300 : 32'h44);
            mem_ack = 1; mem_rdata = 32'h5000_0000 + n;
            step();
            mem_ack = 0;
            @(negedge CLK);
            chk("s_d_ready", d_ready, exp_owner);
            chk("s_if_ready", if_ready, !exp_owner);
            if (exp_owner)
                chk("s_d_rdata", d_rdata, 32'h5000_0000 + n);
            else
                chk("s_if_rdata", if_rdata, 32'h5000_0004);
            step();
        end
        if_req = 0; d_req = 0;

        // Timeout: preload d_rdata, then a load that never acks
        do_reset();
        d_req = 1; d_we = 0; d_addr = 32'h1F0;
        step();
        mem_ack = 1; mem_rdata = 32'h0BAD_F00D;
        step();
        mem_ack = 0; d_req = 0;
        @(negedge CLK);
        chk("t_pre_rdata", d_rdata, 32'h0BAD_F00D);
        step();
        d_req = 1; d_addr = 32'h200;
        step();
        for (int i = 1; i < TIMEOUT; i++) step();
        @(negedge CLK);
        chk("t_last_acc_req", mem_req, 1);
        chk("t_last_acc_ready", d_ready, 0);
        step();
        d_req = 0;
        @(negedge CLK);
        chk("t_d_ready", d_ready, 1);
        chk("t_bus_err", bus_err, 1);
        chk("t_d_rdata", d_rdata, 0);
        step();
        @(negedge CLK);
        chk("t_err_clear", bus_err, 0);
        chk("t_ready_clear", d_ready, 0);
        d_req = 1; d_addr = 32'h204;
        step();
        mem_ack = 1; mem_rdata = 32'h600D_0001;
        step();
        mem_ack = 0; d_req = 0;
        @(negedge CLK);
        chk("t_next_ready", d_ready, 1);
        chk("t_next_err", bus_err, 0);
        chk("t_next_rdata", d_rdata, 32'h600D_0001);
        step();

        // Reset mid-access with a simultaneous ack
        d_req = 1; d_we = 0; d_addr = 32'h208;
        step();
        @(negedge CLK);
        chk("r_acc_req", mem_req, 1);
        chk("r_acc_owner", owner, 1);
        RESET = 1; mem_ack = 1; mem_rdata = 32'hDEAD_BEEF;
        step();
        RESET = 0; mem_ack = 0; d_req = 0;
        @(negedge CLK);
        chk("r_mem_req", mem_req, 0);
        chk("r_d_ready", d_ready, 0);
        chk("r_owner", owner, 0);
        chk("r_d_rdata", d_rdata, 0);
        // A stray ack while idle must not produce a completion
        mem_ack = 1;
        step();
        mem_ack = 0;
        @(negedge CLK);
        chk("r_idle_ready", d_ready | if_ready, 0);
        chk("r_idle_mem_req", mem_req, 0);

        // Ack arrives exactly on the timeout cycle: success
        d_req = 1; d_addr = 32'h20C;
        step();
        for (int i = 1; i < TIMEOUT; i++) step();
        mem_ack = 1; mem_rdata = 32'h7E57_0001;
        step();
        mem_ack = 0; d_req = 0;
        @(negedge CLK);
        chk("tie_d_ready", d_ready, 1);
        chk("tie_bus_err", bus_err, 0);
        chk("tie_d_rdata", d_rdata, 32'h7E57_0001);
        step();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
